// File: rtl/basic_datapath_regs.sv
// Register and storage end of the basic computer.
// PC, AR, IR, DR, AC, V, word memory, SC and decodes.
module basic_datapath_regs #(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int SC_LAST   = 10,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        ar_we,
  input  logic [11:0] ar_d,
  input  logic [15:0] ir_d,
  input  logic        dr_we,
  input  logic [15:0] dr_d,
  input  logic        ac_we,
  input  logic [15:0] ac_d,
  input  logic        pc_incr,
  input  logic        v_en,
  input  logic        alu_v,
  input  logic        mem_we,
  output logic [11:0] pc,
  output logic [11:0] ar,
  output logic [15:0] ir,
  output logic [15:0] dr,
  output logic [15:0] ac,
  output logic        v_flag,
  output logic [15:0] m_data,
  output logic [3:0]  sc,
  output logic [15:0] t_dec,
  output logic [7:0]  d_dec,
  output logic        chk_incr_pc
);

  logic [15:0] mem [MEM_DEPTH];
  logic        halted;
  logic        wr_ok;

  assign halted = halt && (sc == 4'd0);
  assign wr_ok  = ~halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      ar     <= '0;
      ir     <= '0;
      dr     <= '0;
      ac     <= '0;
      v_flag <= 1'b0;
      sc     <= '0;
    end else begin
      if (halted || sc == 4'(SC_LAST)) begin
        sc <= '0;
      end else begin
        sc <= sc + 4'd1;
      end
      if (wr_ok) begin
        if (ar_we)    ar     <= ar_d;
        if (t_dec[2]) ir     <= ir_d;
        if (dr_we)    dr     <= dr_d;
        if (ac_we)    ac     <= ac_d;
        if (pc_incr)  pc     <= pc + 12'd1;
        if (v_en)     v_flag <= alu_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok && mem_we) begin
      mem[ar[ADDR_W-1:0]] <= ac;
    end
  end

  assign m_data = mem[ar[ADDR_W-1:0]];

  assign t_dec = 16'd1 << sc;
  assign d_dec = 8'd1 << ir[14:12];

  assign chk_incr_pc = t_dec[6] & d_dec[7]
                     & ~ir[15] & ir[0]
                     & (ac == 16'd0);

endmodule

// File: tb/tb_basic_datapath_regs.sv
// Bench for basic_datapath_regs: directed steps plus random traffic,
// all checked against an arithmetic model of the register file.
module tb_basic_datapath_regs;

    logic        clk = 1'b0;
    logic        rst, halt, ar_we, dr_we, ac_we, pc_incr, v_en, alu_v, mem_we;
    logic [11:0] ar_d;
    logic [15:0] ir_d, dr_d, ac_d;
    logic [11:0] pc, ar;
    logic [15:0] ir, dr, ac, m_data, t_dec;
    logic        v_flag, chk_incr_pc;
    logic [3:0]  sc;
    logic [7:0]  d_dec;

    always #5 clk = ~clk;

    basic_datapath_regs dut (
        .clk(clk), .rst(rst), .halt(halt),
        .ar_we(ar_we), .ar_d(ar_d), .ir_d(ir_d),
        .dr_we(dr_we), .dr_d(dr_d), .ac_we(ac_we), .ac_d(ac_d),
        .pc_incr(pc_incr), .v_en(v_en), .alu_v(alu_v), .mem_we(mem_we),
        .pc(pc), .ar(ar), .ir(ir), .dr(dr), .ac(ac), .v_flag(v_flag),
        .m_data(m_data), .sc(sc), .t_dec(t_dec), .d_dec(d_dec),
        .chk_incr_pc(chk_incr_pc)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [11:0] m_pc, m_ar;
    logic [15:0] m_ir, m_dr, m_ac;
    logic        m_v;
    int          m_sc;
    logic [15:0] m_mem [256];
    bit          m_known [256];

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ar = 0; m_ir = 0; m_dr = 0; m_ac = 0;
        m_v = 0; m_sc = 0;
    endtask

    task automatic check_all();
        int  op;
        int  idx;
        logic skip;
        op   = int'(m_ir[14:12]);
        idx  = int'(m_ar) % 256;
        skip = (m_sc == 6) && (op == 7) && !m_ir[15] && m_ir[0]
               && (m_ac == 0);
        chk("pc", {4'h0, pc}, {4'h0, m_pc});
        chk("ar", {4'h0, ar}, {4'h0, m_ar});
        chk("ir", ir, m_ir);
        chk("dr", dr, m_dr);
        chk("ac", ac, m_ac);
        chk("v_flag", {15'h0, v_flag}, {15'h0, m_v});
        chk("sc", {12'h0, sc}, 16'(m_sc));
        chk("t_dec", t_dec, 16'(1 << m_sc));
        chk("d_dec", {8'h0, d_dec}, 16'(1 << op));
        chk("chk_incr_pc", {15'h0, chk_incr_pc}, {15'h0, skip});
        if (m_known[idx]) chk("m_data", m_data, m_mem[idx]);
    endtask

    // Check current outputs, advance one clock, advance the model
    task automatic step();
        logic [11:0] n_pc, n_ar;
        logic [15:0] n_ir, n_dr, n_ac;
        logic        n_v, do_wr, stall;
        int          n_sc, widx;
        logic [15:0] wdata;
        check_all();
        n_pc = m_pc; n_ar = m_ar; n_ir = m_ir; n_dr = m_dr;
        n_ac = m_ac; n_v = m_v;
        do_wr = 0; widx = int'(m_ar) % 256; wdata = m_ac;
        if (rst) begin
            n_pc = 0; n_ar = 0; n_ir = 0; n_dr = 0; n_ac = 0;
            n_v = 0; n_sc = 0;
        end else begin
            stall = halt && (m_sc == 0);
            n_sc  = stall ? 0 : (m_sc + 1) % 11;
            if (!stall) begin
                if (ar_we)     n_ar = ar_d;
                if (m_sc == 2) n_ir = ir_d;
                if (dr_we)     n_dr = dr_d;
                if (ac_we)     n_ac = ac_d;
                if (pc_incr)   n_pc = 12'((int'(m_pc) + 1) % 4096);
                if (v_en)      n_v  = alu_v;
                do_wr = mem_we;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_ar = n_ar; m_ir = n_ir; m_dr = n_dr;
        m_ac = n_ac; m_v = n_v; m_sc = n_sc;
        if (do_wr) begin
            m_mem[widx]   = wdata;
            m_known[widx] = 1'b1;
        end
    endtask

    task automatic set_idle();
        rst = 0; halt = 0; ar_we = 0; ar_d = 0; ir_d = 0;
        dr_we = 0; dr_d = 0; ac_we = 0; ac_d = 0; pc_incr = 0;
        v_en = 0; alu_v = 0; mem_we = 0;
    endtask

    task automatic run_to(input int n);
        for (int i = 0; i < 12 && m_sc != n; i++) step();
        chk("run_to_sc", 16'(m_sc), 16'(n));
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        set_idle(); ac_we = 1; ac_d = d; step();
        set_idle(); ar_we = 1; ar_d = a; step();
        set_idle(); mem_we = 1; step();
        set_idle();
    endtask

    task automatic skip_case(input logic [15:0] irv, input logic [15:0] acv,
                             input logic expv, input string tag);
        set_idle(); run_to(2);
        ir_d = irv; step();
        set_idle(); ac_we = 1; ac_d = acv; step();
        set_idle(); run_to(6);
        chk(tag, {15'h0, chk_incr_pc}, {15'h0, expv});
    endtask

    initial begin
        set_idle();
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();
        step();
        set_idle();
        chk("reset_t_dec", t_dec, 16'h0001);
        chk("reset_d_dec", {8'h0, d_dec}, 16'h0001);

        // Free-running sequence: 0..10 then back to 0
        for (int i = 0; i < 12; i++) step();
        chk("sc_after_wrap", {12'h0, sc}, 16'd1);

        // Fetch
        poke(12'h000, 16'h7801);
        run_to(0);
        ar_we = 1; ar_d = 12'h000; step();
        set_idle(); step();
        chk("fetch_mdata", m_data, 16'h7801);
        ir_d = 16'h7801; pc_incr = 1; step();
        set_idle();
        chk("fetch_ir", ir, 16'h7801);
        chk("fetch_d_dec", {8'h0, d_dec}, 16'h0080);
        chk("fetch_pc", {4'h0, pc}, 16'h0001);

        // PC wrap
        pc_incr = 1;
        while (m_pc != 12'hFFF) step();
        chk("pc_max", {4'h0, pc}, 16'h0FFF);
        step();
        chk("pc_wrap", {4'h0, pc}, 16'h0000);
        set_idle();

        // Store / readback
        poke(12'h020, 16'h1234);
        ac_we = 1; ac_d = 16'hBEEF; step();
        set_idle(); mem_we = 1;
        chk("store_old", m_data, 16'h1234);
        step();
        set_idle();
        chk("store_new", m_data, 16'hBEEF);
        chk("store_ac", ac, 16'hBEEF);
        ar_we = 1; ar_d = 12'h321; step();
        set_idle(); mem_we = 1; ac_we = 1; ac_d = 16'hCAFE; step();
        set_idle();
        chk("store_pre_ac", m_data, 16'hBEEF);
        chk("store_ac_new", ac, 16'hCAFE);

        // Skip request
        skip_case(16'h7001, 16'h0000, 1'b1, "skip_ac0");
        skip_case(16'h7001, 16'h0001, 1'b0, "skip_ac1");
        skip_case(16'hF001, 16'h0000, 1'b0, "skip_ir15");

        // Halt
        set_idle(); run_to(5);
        halt = 1; run_to(0);
        ac_we = 1; ac_d = 16'h5555;
        for (int i = 0; i < 3; i++) step();
        chk("halt_sc", {12'h0, sc}, 16'h0000);
        chk("halt_ac", ac, 16'h0000);
        set_idle(); step();
        chk("resume_sc", {12'h0, sc}, 16'h0001);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom % 60) == 0;
            halt    = ($urandom % 6) == 0;
            ar_we   = $urandom % 2;
            ar_d    = 12'($urandom) & 12'hF0F;
            ir_d    = 16'($urandom);
            dr_we   = $urandom % 2;
            dr_d    = 16'($urandom);
            ac_we   = $urandom % 2;
            ac_d    = ($urandom % 4 == 0) ? 16'h0 : 16'($urandom);
            pc_incr = $urandom % 2;
            v_en    = $urandom % 2;
            alu_v   = $urandom % 2;
            mem_we  = $urandom % 2;
            step();
        end
        set_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
